load_extend_unit: RTL and testbench
===================================

Name: load_extend_unit

Overview:
Multi-cycle load path for the MIPS core. It accepts a load request from the datapath and issues one word read on the Avalon-style data bus, waiting out waitrequest. It then byte-selects, sign/zero-extends or LWL/LWR-merges the returned data into the writeback value. It generalises the core's immediate extension to load data, with bus timeout and alignment checking.

Parameters:
ADDR_W, 32, byte address width
TIMEOUT_CYCLES, 255, max waitrequest cycles before bus_error; 0 disables timeout
CNT_W, 16, width of the stall counter (optional feature only)

Ports:
clk  input  1  clock, rising edge
reset_n  input  1  asynchronous, active-low reset
start  input  1  request strobe, sampled in IDLE only
opcode  input  6  OPCODE_LB/LBU/LH/LHU/LW/LWL/LWR from shared package
addr  input  ADDR_W  effective byte address
rt_old  input  32  current rt value, merged by LWL/LWR
busy  output  1  high in any state other than IDLE
avm_address  output  ADDR_W  word address: addr with [1:0] forced to 0
avm_read  output  1  read strobe
avm_byteenable  output  4  always 4'b1111 during read
avm_waitrequest  input  1  bus stall
avm_readdata  input  32  bus read data
wb_valid  output  1  one-cycle pulse, wb_data valid
wb_data  output  32  extended/merged load result
addr_error  output  1  one-cycle pulse on misaligned request
bus_error  output  1  one-cycle pulse on timeout

Behaviour:
- Reset: state IDLE. busy, avm_read, wb_valid, addr_error, bus_error=0. wb_data, avm_address, stall_count=0. Asynchronous assertion mid-read drops avm_read immediately, with no writeback.
- The request (opcode, addr[1:0], rt_old, address) is registered on accept. All later outputs use the registered copies.
- IDLE: start with a load opcode triggers an alignment check.
  - LW needs addr[1:0]==0. LH/LHU need addr[0]==0. LB/LBU/LWL/LWR are always aligned.
  - Misaligned: addr_error pulses in the next cycle; state stays IDLE, no bus access.
  - Aligned: next state READ.
  - start with a non-load opcode is ignored; no pulse.
- READ: avm_read=1 and address held stable.
  - While waitrequest=1, the timeout counter increments.
  - Reaching TIMEOUT_CYCLES: bus_error pulses, avm_read drops, state returns to IDLE.
  - When waitrequest=0: readdata is captured, the result is computed, wb_valid pulses next cycle in DONE.
- DONE: one cycle with wb_valid=1, then IDLE. wb_data holds its value until the next DONE.
- Latency: start at cycle N; minimum wb_valid at N+2 (READ at N+1 with waitrequest=0). Each stall cycle adds 1.
- start while busy is ignored. A new start is accepted only in IDLE, so back-to-back requests are at least 3 cycles apart.
- Data formation is little-endian; k = registered addr[1:0]; B[i] = readdata byte i.
  - LB/LBU: byte B[k], sign/zero-extended.
  - LH/LHU: half {B[k+1],B[k]}, sign/zero-extended.
  - LW: full word.
  - LWL: (readdata << 8*(3-k)) merged with rt_old low (3-k) bytes. k=3 gives the full word.
  - LWR: (readdata >> 8*k) merged with rt_old high k bytes. k=0 gives the full word.
- Timeout counter is cleared on entering READ. It has width $clog2(TIMEOUT_CYCLES+1); with TIMEOUT_CYCLES=0 it is unused and never fires.

Optional Feature:
LOAD_EXT_STALL_COUNT_EN.
- Defined: adds output stall_count[CNT_W-1:0], counting READ cycles with waitrequest=1. It saturates at all-ones, is reset only by reset_n, and is used for performance measurement.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package: OPCODE_LB/LBU/LH/LHU/LW/LWL/LWR constants, a state enum typedef (IDLE, READ, DONE), and an is_load helper constant list.
- One sub-module, load_data_format: purely combinational byte select, extend and LWL/LWR merge from (opcode, k, readdata, rt_old). It is also reusable for unit test.

Test Plan:
1. LB, addr=0x1003, readdata=0x80FF_0000, waitrequest=0 -> wb_valid at start+2, wb_data=0xFFFF_FF80, avm_address=0x1000.
2. LHU, addr=0x2002, readdata=0xBEEF_1234, 3 stall cycles -> wb_valid at start+5, wb_data=0x0000_BEEF; stall_count=3 if enabled.
3. LW addr=0x0001 -> addr_error pulse one cycle, avm_read never asserted; LH addr=0x0003 -> same.
4. LWL addr k=1, readdata=0x4433_2211, rt_old=0xAABB_CCDD -> wb_data=0x2211_CCDD; LWR k=1, same data -> wb_data=0xAA44_3322.
5. TIMEOUT_CYCLES=4, waitrequest held high -> bus_error after 4 stall cycles, no wb_valid, busy low next cycle; a second start while busy is ignored.
6. reset_n low during READ -> avm_read=0 same cycle, outputs at reset values; after release, LBU addr=0x3000, readdata=0x0000_00F0 -> wb_data=0x0000_00F0.

Source files
------------

// File: rtl/load_extend_unit_pkg.sv
// Shared definitions for the load path: MIPS load opcodes, FSM state type
// and request classification helpers.
package load_extend_unit_pkg;

    localparam logic [5:0] OPCODE_LB  = 6'h20;
    localparam logic [5:0] OPCODE_LH  = 6'h21;
    localparam logic [5:0] OPCODE_LWL = 6'h22;
    localparam logic [5:0] OPCODE_LW  = 6'h23;
    localparam logic [5:0] OPCODE_LBU = 6'h24;
    localparam logic [5:0] OPCODE_LHU = 6'h25;
    localparam logic [5:0] OPCODE_LWR = 6'h26;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic is_load(input logic [5:0] op);
        case (op)
            OPCODE_LB, OPCODE_LBU, OPCODE_LH, OPCODE_LHU,
            OPCODE_LW, OPCODE_LWL, OPCODE_LWR: is_load = 1'b1;
            default:                           is_load = 1'b0;
        endcase
    endfunction

    // LWL/LWR exist precisely to handle unaligned words, so they never fault.
    function automatic logic is_aligned(input logic [5:0] op, input logic [1:0] a);
        case (op)
            OPCODE_LW:             is_aligned = (a == 2'b00);
            OPCODE_LH, OPCODE_LHU: is_aligned = ~a[0];
            default:               is_aligned = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/load_extend_unit_format.sv
// Combinational load data formation: little-endian byte/half select with
// sign/zero extension, and LWL/LWR merge with the old rt value.
module load_data_format
    import load_extend_unit_pkg::*;
(
    input  logic [5:0]  opcode,
    input  logic [1:0]  k,
    input  logic [31:0] readdata,
    input  logic [31:0] rt_old,
    output logic [31:0] result
);

    logic [31:0] shifted;
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    always_comb begin
        shifted  = readdata >> {k, 3'b000};
        sel_byte = shifted[7:0];
        sel_half = k[1] ? readdata[31:16] : readdata[15:0];
        result   = readdata;
        case (opcode)
            OPCODE_LB:  result = {{24{sel_byte[7]}}, sel_byte};
            OPCODE_LBU: result = {24'h0, sel_byte};
            OPCODE_LH:  result = {{16{sel_half[15]}}, sel_half};
            OPCODE_LHU: result = {16'h0, sel_half};
            OPCODE_LWL: begin
                case (k)
                    2'd0:    result = {readdata[7:0],  rt_old[23:0]};
                    2'd1:    result = {readdata[15:0], rt_old[15:0]};
                    2'd2:    result = {readdata[23:0], rt_old[7:0]};
                    default: result = readdata;
                endcase
            end
            OPCODE_LWR: begin
                case (k)
                    2'd0:    result = readdata;
                    2'd1:    result = {rt_old[31:24], readdata[31:8]};
                    2'd2:    result = {rt_old[31:16], readdata[31:16]};
                    default: result = {rt_old[31:8],  readdata[31:24]};
                endcase
            end
            default:    result = readdata;
        endcase
    end

endmodule

// File: rtl/load_extend_unit.sv
// Multi-cycle load unit: one word read on an Avalon-style bus, then extend/merge.
// Optional LOAD_EXT_STALL_COUNT_EN adds a saturating waitrequest stall counter.
module load_extend_unit
    import load_extend_unit_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [5:0]        opcode,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       rt_old,
    output logic              busy,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    output logic [3:0]        avm_byteenable,
    input  logic              avm_waitrequest,
    input  logic [31:0]       avm_readdata,
    output logic              wb_valid,
    output logic [31:0]       wb_data,
    output logic              addr_error,
    output logic              bus_error
`ifdef LOAD_EXT_STALL_COUNT_EN
    ,
    output logic [CNT_W-1:0]  stall_count
`endif
);

    localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    state_t      state;
    logic [5:0]  op_q;
    logic [1:0]  k_q;
    logic [31:0] rt_q;
    logic [TW-1:0] tcnt;
    logic [31:0] fmt_data;

    load_data_format u_fmt (
        .opcode   (op_q),
        .k        (k_q),
        .readdata (avm_readdata),
        .rt_old   (rt_q),
        .result   (fmt_data)
    );

    assign avm_byteenable = avm_read ? 4'b1111 : 4'b0000;

    // Bus handshake: avm_read and avm_address stay constant while
    // avm_waitrequest is high; the read completes on the first READ cycle
    // with avm_waitrequest low, when avm_readdata is taken.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            busy        <= 1'b0;
            avm_read    <= 1'b0;
            avm_address <= '0;
            wb_valid    <= 1'b0;
            wb_data     <= '0;
            addr_error  <= 1'b0;
            bus_error   <= 1'b0;
            op_q        <= '0;
            k_q         <= '0;
            rt_q        <= '0;
            tcnt        <= '0;
        end else begin
            wb_valid   <= 1'b0;
            addr_error <= 1'b0;
            bus_error  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && is_load(opcode)) begin
                        if (is_aligned(opcode, addr[1:0])) begin
                            op_q        <= opcode;
                            k_q         <= addr[1:0];
                            rt_q        <= rt_old;
                            avm_address <= {addr[ADDR_W-1:2], 2'b00};
                            avm_read    <= 1'b1;
                            busy        <= 1'b1;
                            tcnt        <= '0;
                            state       <= READ;
                        end else begin
                            addr_error <= 1'b1;
                        end
                    end
                end
                READ: begin
                    if (!avm_waitrequest) begin
                        wb_data  <= fmt_data;
                        wb_valid <= 1'b1;
                        avm_read <= 1'b0;
                        state    <= DONE;
                    end else if ((TIMEOUT_CYCLES != 0) && (tcnt == TO_LAST)) begin
                        bus_error <= 1'b1;
                        avm_read  <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy     <= 1'b0;
                    avm_read <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

`ifdef LOAD_EXT_STALL_COUNT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_count <= '0;
        end else if ((state == READ) && avm_waitrequest && (stall_count != {CNT_W{1'b1}})) begin
            stall_count <= stall_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_load_extend_unit.sv
// Directed bench for load_extend_unit with hand-computed expected results;
// built with TIMEOUT_CYCLES=4 so the bus timeout is reachable quickly.
module tb_load_extend_unit;
    import load_extend_unit_pkg::*;

    localparam int ADDR_W = 32;

    logic              clk;
    logic              reset_n;
    logic              start;
    logic [5:0]        opcode;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       rt_old;
    logic              busy;
    logic [ADDR_W-1:0] avm_address;
    logic              avm_read;
    logic [3:0]        avm_byteenable;
    logic              avm_waitrequest;
    logic [31:0]       avm_readdata;
    logic              wb_valid;
    logic [31:0]       wb_data;
    logic              addr_error;
    logic              bus_error;
`ifdef LOAD_EXT_STALL_COUNT_EN
    logic [15:0]       stall_count;
`endif

    int total;
    int bad;

    load_extend_unit #(
        .ADDR_W         (ADDR_W),
        .TIMEOUT_CYCLES (4),
        .CNT_W          (16)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .start           (start),
        .opcode          (opcode),
        .addr            (addr),
        .rt_old          (rt_old),
        .busy            (busy),
        .avm_address     (avm_address),
        .avm_read        (avm_read),
        .avm_byteenable  (avm_byteenable),
        .avm_waitrequest (avm_waitrequest),
        .avm_readdata    (avm_readdata),
        .wb_valid        (wb_valid),
        .wb_data         (wb_data),
        .addr_error      (addr_error),
        .bus_error       (bus_error)
`ifdef LOAD_EXT_STALL_COUNT_EN
        ,
        .stall_count     (stall_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver: issue one load and wait (bounded) for wb_valid. lat is the
    // number of cycles from the start cycle to wb_valid, -1 if it never came.
    task automatic do_load(input logic [5:0] op, input logic [31:0] a,
                           input logic [31:0] rt, input logic [31:0] rd,
                           input int stalls, output logic [31:0] data,
                           output int lat, output logic [31:0] addr_seen,
                           output logic read_seen);
        @(negedge clk);
        start = 1'b1; opcode = op; addr = a; rt_old = rt;
        avm_readdata = rd; avm_waitrequest = (stalls > 0);
        lat = -1; data = '0; addr_seen = '0; read_seen = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (c == 1) begin
                addr_seen = avm_address;
                read_seen = avm_read && (avm_byteenable == 4'b1111);
            end
            avm_waitrequest = (c <= stalls);
            if (wb_valid) begin
                lat = c;
                data = wb_data;
                break;
            end
        end
        avm_waitrequest = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        total++;
        if ({busy, avm_read, wb_valid, addr_error, bus_error} !== 5'b0) begin
            bad++;
            $display("FAIL reset_flags: got %b need 00000",
                     {busy, avm_read, wb_valid, addr_error, bus_error});
        end
        total++;
        if (wb_data !== 32'h0 || avm_address !== 32'h0) begin
            bad++;
            $display("FAIL reset_regs: wb_data=%h avm_address=%h need 0", wb_data, avm_address);
        end
        reset_n = 1'b1;
        @(negedge clk);
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_release_busy: got %b need 0", busy);
        end
`ifdef LOAD_EXT_STALL_COUNT_EN
        total++;
        if (stall_count !== 16'h0) begin
            bad++;
            $display("FAIL reset_stall_count: got %0d need 0", stall_count);
        end
`endif
    endtask

    task automatic test_lb_basic();
        logic [31:0] d, as;
        int lat;
        logic rs;
        do_load(OPCODE_LB, 32'h1003, 32'h0, 32'h80FF_0000, 0, d, lat, as, rs);
        total++;
        if (lat !== 2 || d !== 32'hFFFF_FF80) begin
            bad++;
            $display("FAIL lb_basic: lat=%0d data=%h need lat=2 data=ffffff80", lat, d);
        end
        total++;
        if (as !== 32'h1000 || rs !== 1'b1) begin
            bad++;
            $display("FAIL lb_bus: addr=%h read=%b need addr=00001000 read=1", as, rs);
        end
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || wb_valid !== 1'b0 || wb_data !== 32'hFFFF_FF80) begin
            bad++;
            $display("FAIL lb_after: busy=%b wb_valid=%b wb_data=%h need 0 0 ffffff80",
                     busy, wb_valid, wb_data);
        end
    endtask

    task automatic test_lhu_stall();
        logic [31:0] d, as;
        int lat;
        logic rs;
        do_load(OPCODE_LHU, 32'h2002, 32'h0, 32'hBEEF_1234, 3, d, lat, as, rs);
        total++;
        if (lat !== 5 || d !== 32'h0000_BEEF || as !== 32'h2000) begin
            bad++;
            $display("FAIL lhu_stall: lat=%0d data=%h addr=%h need 5 0000beef 00002000",
                     lat, d, as);
        end
`ifdef LOAD_EXT_STALL_COUNT_EN
        total++;
        if (stall_count !== 16'd3) begin
            bad++;
            $display("FAIL stall_count: got %0d need 3", stall_count);
        end
`endif
    endtask

    task automatic test_misaligned();
        logic [5:0]  ops [3];
        logic [31:0] adrs [3];
        logic        need_err [3];
        ops[0] = OPCODE_LW; adrs[0] = 32'h0001; need_err[0] = 1'b1;
        ops[1] = OPCODE_LH; adrs[1] = 32'h0003; need_err[1] = 1'b1;
        ops[2] = 6'h08;     adrs[2] = 32'h0001; need_err[2] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            start = 1'b1; opcode = ops[i]; addr = adrs[i];
            @(negedge clk);
            start = 1'b0;
            total++;
            if (addr_error !== need_err[i] || avm_read !== 1'b0 || busy !== 1'b0) begin
                bad++;
                $display("FAIL misaligned_%0d: addr_error=%b avm_read=%b busy=%b need %b 0 0",
                         i, addr_error, avm_read, busy, need_err[i]);
            end
            @(negedge clk);
            total++;
            if (addr_error !== 1'b0 || avm_read !== 1'b0) begin
                bad++;
                $display("FAIL misaligned_pulse_%0d: addr_error=%b avm_read=%b need 0 0",
                         i, addr_error, avm_read);
            end
        end
    endtask

    task automatic test_formats();
        logic [5:0]  ops  [9];
        logic [31:0] adrs [9];
        logic [31:0] rds  [9];
        logic [31:0] exps [9];
        logic [31:0] d, as;
        int lat;
        logic rs;
        ops[0] = OPCODE_LWL; adrs[0] = 32'h0101; rds[0] = 32'h4433_2211; exps[0] = 32'h2211_CCDD;
        ops[1] = OPCODE_LWR; adrs[1] = 32'h0101; rds[1] = 32'h4433_2211; exps[1] = 32'hAA44_3322;
        ops[2] = OPCODE_LWL; adrs[2] = 32'h0103; rds[2] = 32'h4433_2211; exps[2] = 32'h4433_2211;
        ops[3] = OPCODE_LWR; adrs[3] = 32'h0100; rds[3] = 32'h4433_2211; exps[3] = 32'h4433_2211;
        ops[4] = OPCODE_LWL; adrs[4] = 32'h0100; rds[4] = 32'h4433_2211; exps[4] = 32'h11BB_CCDD;
        ops[5] = OPCODE_LWR; adrs[5] = 32'h0103; rds[5] = 32'h4433_2211; exps[5] = 32'hAABB_CC44;
        ops[6] = OPCODE_LH;  adrs[6] = 32'h0200; rds[6] = 32'h0000_8001; exps[6] = 32'hFFFF_8001;
        ops[7] = OPCODE_LW;  adrs[7] = 32'h0010; rds[7] = 32'hDEAD_BEEF; exps[7] = 32'hDEAD_BEEF;
        ops[8] = OPCODE_LBU; adrs[8] = 32'h0001; rds[8] = 32'h0000_9A00; exps[8] = 32'h0000_009A;
        for (int i = 0; i < 9; i++) begin
            do_load(ops[i], adrs[i], 32'hAABB_CCDD, rds[i], 0, d, lat, as, rs);
            total++;
            if (lat !== 2 || d !== exps[i] || as !== {adrs[i][31:2], 2'b00}) begin
                bad++;
                $display("FAIL format_%0d: lat=%0d data=%h addr=%h need lat=2 data=%h",
                         i, lat, d, as, exps[i]);
            end
        end
    endtask

    task automatic test_timeout();
        @(negedge clk);
        start = 1'b1; opcode = OPCODE_LW; addr = 32'h0020;
        avm_waitrequest = 1'b1; avm_readdata = 32'h1234_5678;
        @(negedge clk);
        // Start held while busy with a different request must be ignored.
        opcode = OPCODE_LB; addr = 32'h0777;
        total++;
        if (avm_read !== 1'b1 || avm_address !== 32'h0020 || busy !== 1'b1) begin
            bad++;
            $display("FAIL timeout_read: avm_read=%b addr=%h busy=%b need 1 00000020 1",
                     avm_read, avm_address, busy);
        end
        for (int i = 2; i <= 4; i++) begin
            @(negedge clk);
            start = 1'b0;
            total++;
            if (avm_read !== 1'b1 || bus_error !== 1'b0 || avm_address !== 32'h0020) begin
                bad++;
                $display("FAIL timeout_wait_%0d: avm_read=%b bus_error=%b addr=%h need 1 0 00000020",
                         i, avm_read, bus_error, avm_address);
            end
        end
        @(negedge clk);
        total++;
        if (bus_error !== 1'b1 || avm_read !== 1'b0 || busy !== 1'b0 || wb_valid !== 1'b0) begin
            bad++;
            $display("FAIL timeout_fire: bus_error=%b avm_read=%b busy=%b wb_valid=%b need 1 0 0 0",
                     bus_error, avm_read, busy, wb_valid);
        end
        avm_waitrequest = 1'b0;
        @(negedge clk);
        total++;
        if (bus_error !== 1'b0 || wb_valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL timeout_after: bus_error=%b wb_valid=%b busy=%b need 0 0 0",
                     bus_error, wb_valid, busy);
        end
    endtask

    task automatic test_reset_mid_read();
        logic [31:0] d, as;
        int lat;
        logic rs;
        @(negedge clk);
        start = 1'b1; opcode = OPCODE_LB; addr = 32'h0040; avm_waitrequest = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        total++;
        if (avm_read !== 1'b1) begin
            bad++;
            $display("FAIL rst_mid_pre: avm_read=%b need 1", avm_read);
        end
        #2 reset_n = 1'b0;
        #1;
        total++;
        if ({busy, avm_read, wb_valid, bus_error} !== 4'b0 || wb_data !== 32'h0 ||
            avm_address !== 32'h0) begin
            bad++;
            $display("FAIL rst_mid: flags=%b wb_data=%h addr=%h need 0000 0 0",
                     {busy, avm_read, wb_valid, bus_error}, wb_data, avm_address);
        end
`ifdef LOAD_EXT_STALL_COUNT_EN
        total++;
        if (stall_count !== 16'h0) begin
            bad++;
            $display("FAIL rst_mid_stall_count: got %0d need 0", stall_count);
        end
`endif
        avm_waitrequest = 1'b0;
        @(negedge clk);
        total++;
        if (wb_valid !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid_no_wb: wb_valid=%b need 0", wb_valid);
        end
        reset_n = 1'b1;
        do_load(OPCODE_LBU, 32'h3000, 32'h0, 32'h0000_00F0, 0, d, lat, as, rs);
        total++;
        if (lat !== 2 || d !== 32'h0000_00F0 || as !== 32'h3000) begin
            bad++;
            $display("FAIL rst_recover: lat=%0d data=%h addr=%h need 2 000000f0 00003000",
                     lat, d, as);
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        reset_n = 1'b0;
        start = 1'b0;
        opcode = '0;
        addr = '0;
        rt_old = '0;
        avm_waitrequest = 1'b0;
        avm_readdata = '0;
        test_reset();
        test_lb_basic();
        test_lhu_stall();
        test_misaligned();
        test_formats();
        test_timeout();
        test_reset_mid_read();
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
